// File: rtl/subkey_sched.sv
// subkey_sched: round-robin scheduler and result collector for a bank of
// crypto1 subkey generator engines. It grants one engine at a time, copies
// that engine's result batch into a local buffer, releases the engine and
// streams the buffered 24-bit candidates out on a valid/ready port.
// Optional build macro SUBKEY_SCHED_PERF_EN adds the STALL_CYCLES and
// IDLE_GRANT performance counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for START
// S_RUN    | launch idle engines, pick next valid engine round-robin
// S_LATCH  | copy granted engine's batch, acknowledge it (one cycle)
// S_DRAIN  | stream buffered candidates downstream
// S_FINISH | all engines retired, raise ALL_DONE (one cycle)

module subkey_sched #(
  parameter int NUM_ENG = 16,
  parameter int EW      = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic                       ABORT,
  input  logic [NUM_ENG-1:0]         ENG_VALID,
  input  logic [NUM_ENG-1:0]         ENG_DONE,
  input  logic [NUM_ENG*4-1:0]       ENG_CNT,
  input  logic [NUM_ENG*16*24-1:0]   ENG_SUBKEY,
  output logic [NUM_ENG-1:0]         ENG_READY,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [23:0]                OUT_KEY,
  output logic [EW-1:0]              OUT_ENG,
  output logic                       OUT_LAST,
  output logic                       BUSY,
  output logic                       ALL_DONE,
  output logic [31:0]                KEY_COUNT
`ifdef SUBKEY_SCHED_PERF_EN
  ,
  output logic [31:0]                STALL_CYCLES,
  output logic [31:0]                IDLE_GRANT
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_LATCH  = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [EW-1:0]        r_ptr;
  logic [EW-1:0]        r_grant;
  logic [NUM_ENG-1:0]   r_retired;
  logic [23:0]          r_buf [16];
  logic [4:0]           r_rd;
  logic                 r_done_lat;
  logic                 r_all_done;
  logic [31:0]          r_key_count;

  logic [NUM_ENG-1:0]   w_cand;
  logic [NUM_ENG-1:0]   w_grant_1h;
  logic [EW-1:0]        w_pick;
  logic [EW-1:0]        w_ptr_nxt;
  logic                 w_found;
  logic                 w_all_retired;
  logic                 w_accept;
  logic                 w_last_acc;
  logic                 w_start_go;
  logic [3:0]           w_cnt;
  logic [4:0]           w_rd_init;

  assign w_cand        = ENG_VALID & ~r_retired;
  assign w_all_retired = (r_retired == {NUM_ENG{1'b1}});
  assign w_accept      = (r_state == S_DRAIN) & OUT_READY;
  assign w_last_acc    = w_accept & (r_rd == 5'd15);
  assign w_start_go    = (r_state == S_IDLE) & START & ~ABORT;
  assign w_cnt         = ENG_CNT[4*r_grant +: 4];
  // A zero count with VALID means a full batch, so reading starts at slot 0.
  assign w_rd_init     = (w_cnt == 4'd0) ? 5'd0 : (5'd16 - {1'b0, w_cnt});
  assign w_ptr_nxt     = (r_grant == EW'(NUM_ENG - 1)) ? '0 : (r_grant + 1'b1);
  assign w_grant_1h    = NUM_ENG'(1) << r_grant;

  // Round-robin search: first candidate at or above the pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_ENG) idx = idx - NUM_ENG;
      if (!w_found && w_cand[EW'(idx)]) begin
        w_found = 1'b1;
        w_pick  = EW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; ABORT overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (ABORT) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (START) w_state_nxt = S_RUN;
        S_RUN: begin
          if (w_found)            w_state_nxt = S_LATCH;
          else if (w_all_retired) w_state_nxt = S_FINISH;
        end
        S_LATCH:  w_state_nxt = S_DRAIN;
        S_DRAIN:  if (w_last_acc) w_state_nxt = S_RUN;
        S_FINISH: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    ENG_READY = '0;
    OUT_VALID = 1'b0;
    OUT_KEY   = '0;
    OUT_ENG   = '0;
    OUT_LAST  = 1'b0;
    case (r_state)
      S_RUN:   ENG_READY = ~ENG_VALID & ~r_retired;
      S_LATCH: ENG_READY = w_grant_1h;
      S_DRAIN: begin
        OUT_VALID = 1'b1;
        OUT_KEY   = r_buf[r_rd[3:0]];
        OUT_ENG   = r_grant;
        OUT_LAST  = (r_rd == 5'd15);
      end
      default: ;
    endcase
  end

  assign BUSY      = (r_state != S_IDLE);
  assign ALL_DONE  = r_all_done;
  assign KEY_COUNT = r_key_count;

  // Scheduler bookkeeping: grant, pointer, read index, retirement, done flag.
  always_ff @(posedge CLK) begin
    if (RESET || ABORT) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_retired  <= '0;
      r_rd       <= '0;
      r_done_lat <= 1'b0;
      r_all_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_all_done <= 1'b0;
            r_retired  <= '0;
          end
        end
        S_RUN: begin
          if (w_found) r_grant <= w_pick;
        end
        S_LATCH: begin
          r_rd       <= w_rd_init;
          r_done_lat <= ENG_DONE[r_grant];
          r_ptr      <= w_ptr_nxt;
        end
        S_DRAIN: begin
          if (w_accept) r_rd <= r_rd + 5'd1;
          if (w_last_acc && r_done_lat) r_retired[r_grant] <= 1'b1;
        end
        S_FINISH: r_all_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Batch buffer; contents only matter while draining, so it has no reset.
  always_ff @(posedge CLK) begin
    if (r_state == S_LATCH) begin
      for (int j = 0; j < 16; j++)
        r_buf[j] <= ENG_SUBKEY[(16*int'(r_grant) + j)*24 +: 24];
    end
  end

  // Running count of accepted candidates; survives ABORT, wraps at 2^32.
  always_ff @(posedge CLK) begin
    if (RESET)         r_key_count <= '0;
    else if (w_accept) r_key_count <= r_key_count + 32'd1;
  end

`ifdef SUBKEY_SCHED_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_idle_grant;
  logic        w_run_idle;

  assign w_run_idle   = (r_state == S_RUN) & ~w_found & ~w_all_retired;
  assign STALL_CYCLES = r_stall_cycles;
  assign IDLE_GRANT   = r_idle_grant;

  // Saturating performance counters, cleared when a run starts.
  always_ff @(posedge CLK) begin
    if (RESET || w_start_go) begin
      r_stall_cycles <= '0;
      r_idle_grant   <= '0;
    end else begin
      if ((r_state == S_DRAIN) && !OUT_READY && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_run_idle && (r_idle_grant != 32'hFFFF_FFFF))
        r_idle_grant <= r_idle_grant + 32'd1;
    end
  end
`else
  logic w_unused_start_go;
  assign w_unused_start_go = w_start_go;
`endif

endmodule

// File: tb/tb_subkey_sched.sv
// tb_subkey_sched: self-checking bench for subkey_sched. Engines are modelled
// behaviourally; expected output order and round-robin grants come from a
// scoreboard and a simple modular pointer model.
`timescale 1ns/1ps

module tb_subkey_sched;

  localparam int N    = 16;
  localparam int EW   = 4;
  localparam int E_W  = 0;   // engine waiting for READY
  localparam int E_S  = 1;   // engine searching
  localparam int E_P  = 2;   // engine presenting a batch
  localparam int E_F  = 3;   // engine finished

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b1;
  logic                 START = 1'b0;
  logic                 ABORT = 1'b0;
  logic [N-1:0]         ENG_VALID = '0;
  logic [N-1:0]         ENG_DONE = '0;
  logic [N*4-1:0]       ENG_CNT = '0;
  logic [N*16*24-1:0]   ENG_SUBKEY = '0;
  logic [N-1:0]         ENG_READY;
  logic                 OUT_VALID;
  logic                 OUT_READY = 1'b1;
  logic [23:0]          OUT_KEY;
  logic [EW-1:0]        OUT_ENG;
  logic                 OUT_LAST;
  logic                 BUSY;
  logic                 ALL_DONE;
  logic [31:0]          KEY_COUNT;
`ifdef SUBKEY_SCHED_PERF_EN
  logic [31:0]          STALL_CYCLES;
  logic [31:0]          IDLE_GRANT;
`endif

  subkey_sched #(.NUM_ENG(N), .EW(EW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .ENG_VALID(ENG_VALID), .ENG_DONE(ENG_DONE), .ENG_CNT(ENG_CNT),
    .ENG_SUBKEY(ENG_SUBKEY), .ENG_READY(ENG_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_KEY(OUT_KEY),
    .OUT_ENG(OUT_ENG), .OUT_LAST(OUT_LAST), .BUSY(BUSY),
    .ALL_DONE(ALL_DONE), .KEY_COUNT(KEY_COUNT)
`ifdef SUBKEY_SCHED_PERF_EN
    , .STALL_CYCLES(STALL_CYCLES), .IDLE_GRANT(IDLE_GRANT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [23:0] key;
    int          eng;
    bit          last;
    bit          done;
  } exp_t;

  // engine models
  int          e_st [N];
  int          e_timer [N];
  int          e_left [N];
  int          e_n [N];
  bit          e_final [N];
  bit          e_done [N];
  logic [23:0] e_slot [N][16];
  bit          hold;

  // reference state
  exp_t        sb [$];
  int          acc_eng [$];
  logic [23:0] acc_key [$];
  int          m_ptr;
  bit [N-1:0]  m_retired;
  bit [N-1:0]  prev_valid;
  int          m_stall;
  bit          ack_prev;
  int          ack_count;
  int          viol;

  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input bit [N-1:0] c, input int p);
    for (int k = 0; k < N; k++) begin
      if (c[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic present(input int e, input int n, input bit fin);
    e_n[e]     = n;
    e_final[e] = fin;
    e_done[e]  = e_done[e] | fin;
    e_st[e]    = E_P;
    for (int j = 0; j < 16; j++) e_slot[e][j] = 24'($urandom);
  endtask

  task automatic drive();
    for (int e = 0; e < N; e++) begin
      ENG_VALID[e]       = (e_st[e] == E_P);
      ENG_DONE[e]        = e_done[e];
      ENG_CNT[4*e +: 4]  = 4'(e_n[e]);
      for (int j = 0; j < 16; j++)
        ENG_SUBKEY[(16*e + j)*24 +: 24] = e_slot[e][j];
    end
  endtask

  // One clock: drive inputs at the falling edge, sample just after, then
  // advance the engine and reference models for the coming rising edge.
  task automatic step(input bit rdy, input bit st, input bit ab);
    int   pick;
    exp_t x;
    @(negedge CLK);
    START = st;
    ABORT = ab;
    OUT_READY = rdy;
    drive();
    #1;
    if (ack_prev) chk("grant_latency", OUT_VALID, 1);
    ack_prev = 0;
    if ((ENG_READY & m_retired) != '0) viol++;
    if (OUT_VALID) begin
      if (sb.size() == 0) begin
        chk("out_valid_unexpected", OUT_VALID, 0);
      end else begin
        chk("out_key", OUT_KEY, sb[0].key);
        chk("out_eng", OUT_ENG, sb[0].eng);
        chk("out_last", OUT_LAST, sb[0].last);
        if (OUT_READY) begin
          x = sb.pop_front();
          acc_key.push_back(OUT_KEY);
          acc_eng.push_back(int'(OUT_ENG));
          if (x.last && x.done) m_retired[x.eng] = 1'b1;
        end
      end
      if (!OUT_READY) m_stall++;
    end
    for (int e = 0; e < N; e++) begin
      if (ENG_READY[e] && e_st[e] == E_W) begin
        if (!hold) begin
          e_st[e]    = E_S;
          e_timer[e] = $urandom_range(0, 5);
        end
      end else if (ENG_READY[e] && e_st[e] == E_P) begin
        pick = rr_pick(prev_valid & ~m_retired, m_ptr);
        chk("rr_grant", e, pick);
        for (int j = 16 - e_n[e]; j < 16; j++)
          sb.push_back('{e_slot[e][j], e, (j == 15), e_final[e]});
        m_ptr = (e + 1) % N;
        ack_prev = 1;
        ack_count++;
        if (e_final[e])  e_st[e] = E_F;
        else if (hold)   e_st[e] = E_W;
        else begin
          e_st[e]    = E_S;
          e_timer[e] = $urandom_range(0, 5);
        end
      end else if (e_st[e] == E_S) begin
        if (e_timer[e] == 0) begin
          if ($urandom_range(0, 99) < 25) e_st[e] = E_W;
          else begin
            e_left[e]--;
            present(e, $urandom_range(1, 16), e_left[e] == 0);
          end
        end else begin
          e_timer[e]--;
        end
      end
    end
    prev_valid = ENG_VALID;
  endtask

  task automatic run_until(input int target, input int maxc);
    int c = 0;
    while ((ack_count < target || sb.size() != 0) && c < maxc) begin
      step(1, 0, 0);
      c++;
    end
    step(1, 0, 0);
  endtask

  initial begin
    int          k;
    int          c;
    logic [23:0] saved;

    hold = 1;
    for (int e = 0; e < N; e++) begin
      e_st[e] = E_W; e_timer[e] = 0; e_left[e] = 0; e_n[e] = 0;
      e_final[e] = 0; e_done[e] = 0;
      for (int j = 0; j < 16; j++) e_slot[e][j] = '0;
    end
    m_ptr = 0; m_retired = '0; prev_valid = '0; m_stall = 0;
    ack_prev = 0; ack_count = 0; viol = 0;

    // reset
    repeat (3) step(1, 0, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_all_done", ALL_DONE, 0);
    chk("rst_key_count", KEY_COUNT, 0);
    chk("rst_eng_ready", ENG_READY, 0);
    chk("rst_out_key", OUT_KEY, 0);
    chk("rst_out_last", OUT_LAST, 0);
    RESET = 1'b0;

    // start with no engine valid: every engine is launched
    step(1, 1, 0);
    m_stall = 0;
    step(1, 0, 0);
    chk("a_eng_ready", ENG_READY, 16'hFFFF);
    chk("a_out_valid", OUT_VALID, 0);
    chk("a_busy", BUSY, 1);

    // engines 0 and 5 together from pointer 0
    k = acc_key.size();
    present(0, 3, 0);
    present(5, 4, 0);
    run_until(ack_count + 2, 200);
    chk("c_nkeys", acc_key.size() - k, 7);
    if (acc_key.size() >= k + 7) begin
      chk("c_first_eng", acc_eng[k], 0);
      chk("c_second_eng", acc_eng[k+3], 5);
    end

    // pointer now 6: engine 7 must win over engine 2
    k = acc_key.size();
    present(7, 1, 0);
    present(2, 1, 0);
    run_until(ack_count + 2, 200);
    chk("p_nkeys", acc_key.size() - k, 2);
    if (acc_key.size() >= k + 2) begin
      chk("p_first_eng", acc_eng[k], 7);
      chk("p_second_eng", acc_eng[k+1], 2);
    end

    // engine 3, two keys
    k = acc_key.size();
    c = ack_count;
    present(3, 2, 0);
    e_slot[3][14] = 24'hABCDEF;
    e_slot[3][15] = 24'h123456;
    run_until(ack_count + 1, 200);
    chk("b_acks", ack_count - c, 1);
    chk("b_nkeys", acc_key.size() - k, 2);
    if (acc_key.size() >= k + 2) begin
      chk("b_key0", acc_key[k], 24'hABCDEF);
      chk("b_key1", acc_key[k+1], 24'h123456);
      chk("b_eng", acc_eng[k], 3);
    end
    chk("b_keycount", KEY_COUNT, acc_key.size());

    // engine 1, CNT=0 means a full 16-key batch
    k = acc_key.size();
    present(1, 16, 0);
    run_until(ack_count + 1, 200);
    chk("d_nkeys", acc_key.size() - k, 16);
    if (acc_key.size() >= k + 16) begin
      chk("d_first_key", acc_key[k], e_slot[1][0]);
      chk("d_last_key", acc_key[k+15], e_slot[1][15]);
    end

    // backpressure for 10 cycles mid-batch
    k = acc_key.size();
    present(4, 16, 0);
    c = 0;
    while (acc_key.size() < k + 4 && c < 100) begin
      step(1, 0, 0);
      c++;
    end
    saved = '0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0);
      if (i == 0) saved = OUT_KEY;
    end
    chk("e_stable_valid", OUT_VALID, 1);
    chk("e_stable_key", OUT_KEY, saved);
    run_until(ack_count, 200);
    chk("e_nkeys", acc_key.size() - k, 16);
`ifdef SUBKEY_SCHED_PERF_EN
    chk("e_stall_cycles", STALL_CYCLES, 10);
`endif

    // abort in the middle of a drain
    k = acc_key.size();
    present(2, 8, 0);
    c = 0;
    while (acc_key.size() < k + 3 && c < 100) begin
      step(1, 0, 0);
      c++;
    end
    step(0, 0, 1);
    step(1, 0, 0);
    chk("f_out_valid", OUT_VALID, 0);
    chk("f_busy", BUSY, 0);
    chk("f_eng_ready", ENG_READY, 0);
    chk("f_keycount", KEY_COUNT, acc_key.size());
    sb.delete();
    m_ptr = 0; m_retired = '0; ack_prev = 0;

    // START together with ABORT stays idle
    step(1, 1, 1);
    step(1, 0, 0);
    chk("sa_busy", BUSY, 0);

    // randomized full run: every engine ends with DONE on its last batch
    hold = 0;
    for (int e = 0; e < N; e++) begin
      e_st[e] = E_W; e_done[e] = 0; e_final[e] = 0; e_n[e] = 0;
      e_left[e] = $urandom_range(1, 3);
    end
    m_stall = 0; m_ptr = 0; m_retired = '0;
    k = acc_key.size();
    step(1, 1, 0);
    c = 0;
    while (!ALL_DONE && c < 20000) begin
      step($urandom_range(0, 3) != 0, 0, 0);
      c++;
    end
    chk("g_all_done", ALL_DONE, 1);
    chk("g_busy", BUSY, 0);
    chk("g_keycount", KEY_COUNT, acc_key.size());
    chk("g_ready_to_retired", viol, 0);
    chk("g_out_valid", OUT_VALID, 0);
`ifdef SUBKEY_SCHED_PERF_EN
    chk("g_stall_cycles", STALL_CYCLES, m_stall);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subkey_sched.md
Name: subkey_sched

Overview:
- Round-robin scheduler and result collector for a bank of NUM_ENG crypto1 subkey generator engines; engine i is built with IDX=i and all engines share one 5-bit bitstream.
- Starts every engine and gates each engine's READY handshake.
- Grants one engine at a time. It copies the granted engine's result batch into a local buffer, then releases that engine to search again.
- Serializes the buffered 24-bit candidates onto one valid/ready output stream.
- Flags completion once every engine has reported DONE and its final batch has been drained.

Parameters:
- NUM_ENG, 16, number of attached engines (1..16).
- EW, 4, width of the engine index; must satisfy 2**EW >= NUM_ENG.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous reset, active-high.
- START  in  1  one-cycle pulse that begins a run; ignored unless in IDLE.
- ABORT  in  1  returns the block to IDLE and drops all state except KEY_COUNT.
- ENG_VALID  in  NUM_ENG  per-engine result-batch-valid.
- ENG_DONE  in  NUM_ENG  per-engine sticky enumeration-complete.
- ENG_CNT  in  NUM_ENG*4  per-engine batch count; engine i occupies bits [4i+3:4i].
- ENG_SUBKEY  in  NUM_ENG*16*24  per-engine subkey slots; slot j of engine i occupies bits [(16i+j)*24 +: 24].
- ENG_READY  out  NUM_ENG  per-engine restart/acknowledge.
- OUT_VALID  out  1  candidate on OUT_KEY is valid.
- OUT_READY  in  1  downstream accepts the candidate.
- OUT_KEY  out  24  candidate subkey.
- OUT_ENG  out  EW  index of the engine that produced OUT_KEY.
- OUT_LAST  out  1  marks the last candidate of the current batch.
- BUSY  out  1  high in every state except IDLE.
- ALL_DONE  out  1  sticky run-complete flag.
- KEY_COUNT  out  32  running total of candidates accepted downstream.

Behaviour:
- Reset values: every output is 0; FSM=IDLE; round-robin pointer=0; retired mask=0.
- Engine contract:
  - An engine waiting between searches starts a new search on a cycle with READY=1 and clears VALID on the same edge.
  - Valid slots of a batch are indices 16-n .. 15, where n = ENG_CNT.
  - ENG_CNT==0 with ENG_VALID=1 means n=16.
- ENG_READY[i] rule (combinational):
  - In RUN, ENG_READY[i] = ~ENG_VALID[i] & ~retired[i]. This launches idle engines and re-launches engines whose search produced no batch.
  - In LATCH, only the granted engine receives ENG_READY=1.
  - In all other states ENG_READY=0.
- IDLE: on START go to RUN; clear ALL_DONE and the retired mask.
- RUN:
  - Candidates are ENG_VALID & ~retired.
  - Pick the first candidate at or above the pointer, wrapping modulo NUM_ENG.
  - If a candidate exists, register the grant index g and go to LATCH.
  - If retired == all ones, go to FINISH.
- LATCH (one cycle):
  - Copy 16x24 slots, n and ENG_DONE[g] into the local buffer.
  - Set rd = 16-n (rd is 5 bits).
  - Pulse ENG_READY[g].
  - Set pointer = (g+1) mod NUM_ENG.
  - Go to DRAIN.
- DRAIN:
  - OUT_VALID=1, OUT_KEY=buf[rd], OUT_ENG=g, OUT_LAST=(rd==15).
  - On OUT_VALID&OUT_READY: rd++ and KEY_COUNT++. KEY_COUNT wraps at 2^32.
  - On accept of the last candidate: if the latched DONE=1, set retired[g]. Go to RUN.
  - OUT_KEY, OUT_ENG and OUT_LAST stay stable while OUT_READY=0.
- FINISH: set ALL_DONE=1; go to IDLE.
- Latency: grant to first OUT_VALID is 2 cycles (RUN to LATCH to DRAIN). A 16-key batch drains in 16 cycles at full OUT_READY.
- ABORT has priority over every transition. It forces IDLE, OUT_VALID=0 and ENG_READY=0 on the next edge. Engines are not reset by this block.
- RESET mid-DRAIN discards the buffer; no partial OUT_LAST is emitted.
- Simultaneous START and ABORT: ABORT wins.
- Retirement: an engine that asserts DONE with VALID is drained, then retired, and is never granted or re-launched again.

Optional Feature:
- Macro: SUBKEY_SCHED_PERF_EN.
- When defined:
  - Adds output STALL_CYCLES[31:0], which counts cycles in DRAIN with OUT_READY=0.
  - Adds output IDLE_GRANT[31:0], which counts RUN cycles with no candidate while not all engines are retired.
  - Both counters clear on START and on RESET, and saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset then START with all ENG_VALID=0 -> ENG_READY=all ones in RUN, OUT_VALID=0, BUSY=1.
- Engine 3 presents CNT=2, slots 14=0xABCDEF and 15=0x123456, OUT_READY=1 -> LATCH pulses ENG_READY[3] once; outputs 0xABCDEF then 0x123456 with OUT_ENG=3; OUT_LAST only on the second; KEY_COUNT=2.
- Engines 0 and 5 are valid simultaneously with pointer=0 -> engine 0 drained first, then engine 5; pointer=6 afterwards.
- Engine 1 presents ENG_CNT=0 with VALID=1 -> 16 candidates emitted from slots 0..15.
- OUT_READY held low 10 cycles mid-batch -> OUT_KEY stable; STALL_CYCLES=10 when SUBKEY_SCHED_PERF_EN is defined.
- Every engine finishes with DONE=1 on its final batch -> each is retired after its batch drains; ALL_DONE=1 and BUSY=0 follow. An ABORT mid-DRAIN instead returns to IDLE next cycle with OUT_VALID=0.
